// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 16;
  localparam int ZERO_IDX     = 0;

  function automatic int addr_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

  typedef logic [addr_w(NUM_REGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Operand-fetch bus: read ports, destination allocation, writeback and flush.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2
);
  localparam int AW = addr_w(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     alloc_valid;
  logic [AW-1:0]            alloc_addr;
  logic                     alloc_ready;
  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic                     err_underflow;

  modport master (
    output rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, alloc_ready, err_underflow
  );

  modport slave (
    input  rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, alloc_ready, err_underflow
  );

endinterface

// File: rtl/regfile_sb_counter.sv
// Saturating up/down counter of outstanding writers for one register.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         is_zero,
  output logic         is_max
);

  assign is_zero = (count == '0);
  assign is_max  = &count;

  // Simultaneous inc and dec cancel; clear beats both; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !is_max) begin
      count <= count + W'(1);
    end else if (dec && !inc && !is_zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with forwarding reads and a per-register pending-writer scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int AW = addr_w(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] is_zero;
  logic [NUM_REGS-1:0] is_max;
  logic wb_to_zero;
  logic alloc_hit_wb;
  logic accept;
  logic err;

  assign wb_to_zero = (ZERO_REG != 0) && (bus.wb_addr == AW'(ZERO_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_valid && !wb_to_zero) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // A full register can still accept a new writer when one retires this cycle.
  assign alloc_hit_wb    = bus.wb_valid && (bus.wb_addr == bus.alloc_addr);
  assign bus.alloc_ready = rst || !(is_max[bus.alloc_addr] && !alloc_hit_wb);
  assign accept          = bus.alloc_valid && bus.alloc_ready && !rst;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = accept && (bus.alloc_addr == AW'(r)) && !((ZERO_REG != 0) && (r == ZERO_IDX));
    assign dec = bus.wb_valid && (bus.wb_addr == AW'(r)) && !is_zero[r];
    sb_counter #(.W(PEND_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .dec     (dec),
      .clr     (bus.flush),
      .count   (cnt[r]),
      .is_zero (is_zero[r]),
      .is_max  (is_max[r])
    );
  end

  // Busy drops in the same cycle that the last outstanding writer returns.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    logic zr;
    assign a   = bus.rd_addr[k*AW +: AW];
    assign hit = bus.wb_valid && (bus.wb_addr == a);
    assign zr  = (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    assign bus.rd_data[k*DATA_W +: DATA_W] = (rst || zr) ? '0 : (hit ? bus.wb_data : regs[a]);
    assign bus.rd_busy[k] = !rst && !zr && !is_zero[a] && !((cnt[a] == PEND_W'(1)) && hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bus.wb_valid && !bus.flush && !wb_to_zero && is_zero[bus.wb_addr]) begin
      err <= 1'b1;
    end
  end

  assign bus.err_underflow = err;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb against a count-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int NUM_RD   = 2;
  localparam int PEND_W   = 2;
  localparam int MAXP     = (1 << PEND_W) - 1;
  localparam int AW       = addr_w(NUM_REGS);

  typedef struct {
    logic [NUM_RD*DATA_W-1:0] data;
    logic [NUM_RD-1:0]        busy;
    logic                     ready;
    logic                     err;
    int                       cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

  regfile_sb #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .PEND_W   (PEND_W),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int   m_regs [NUM_REGS];
  int   m_pend [NUM_REGS];
  bit   m_err;

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic apply_stimulus(input bit r, input int ra0, input int ra1,
                                input bit av, input int aa,
                                input bit wv, input int wa, input int wd,
                                input bit fl);
    exp_t e;
    int   ra [NUM_RD];
    bit   ready;
    @(posedge clk);
    #1;
    cyc++;
    rst             = r;
    bus.rd_addr     = {AW'(ra1), AW'(ra0)};
    bus.alloc_valid = av;
    bus.alloc_addr  = AW'(aa);
    bus.wb_valid    = wv;
    bus.wb_addr     = AW'(wa);
    bus.wb_data     = DATA_W'(wd);
    bus.flush       = fl;
    ra[0] = ra0;
    ra[1] = ra1;
    e.cycle = cyc;
    if (r) begin
      model_reset();
      e.data  = '0;
      e.busy  = '0;
      e.ready = 1'b1;
      e.err   = 1'b0;
      expq.push_back(e);
      return;
    end
    for (int k = 0; k < NUM_RD; k++) begin
      bit hit;
      int left;
      hit  = wv && (wa == ra[k]);
      left = m_pend[ra[k]] - ((hit && m_pend[ra[k]] > 0) ? 1 : 0);
      e.data[k*DATA_W +: DATA_W] = (ra[k] == 0) ? '0 : (hit ? DATA_W'(wd) : DATA_W'(m_regs[ra[k]]));
      e.busy[k] = (ra[k] != 0) && (left != 0);
    end
    ready   = !(m_pend[aa] == MAXP && !(wv && wa == aa));
    e.ready = ready;
    e.err   = m_err;
    expq.push_back(e);
    if (wv && wa != 0) m_regs[wa] = wd & 16'hFFFF;
    if (fl) begin
      for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 0;
    end else begin
      bit do_dec;
      do_dec = wv && m_pend[wa] > 0;
      if (wv && wa != 0 && m_pend[wa] == 0) m_err = 1'b1;
      if (av && ready && aa != 0) m_pend[aa] = m_pend[aa] + 1;
      if (do_dec) m_pend[wa] = m_pend[wa] - 1;
    end
  endtask

  task automatic idle(input int ra0, input int ra1);
    apply_stimulus(0, ra0, ra1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual %0h required %0h", name, c, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    compare("rd_data", 64'(bus.rd_data), 64'(e.data), e.cycle);
    compare("rd_busy", 64'(bus.rd_busy), 64'(e.busy), e.cycle);
    compare("alloc_ready", 64'(bus.alloc_ready), 64'(e.ready), e.cycle);
    compare("err_underflow", 64'(bus.err_underflow), 64'(e.err), e.cycle);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      check_output(expq.pop_front());
    end
  end

  initial begin
    reg_addr_t ra_a, ra_b, a_addr, w_addr;
    bus.rd_addr     = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.flush       = 1'b0;
    model_reset();

    $display("[TB] reset and read");
    apply_stimulus(1, 3, 5, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 3, 5, 1, 3, 1, 3, 16'h1234, 0);
    idle(3, 5);

    $display("[TB] write with forwarding");
    apply_stimulus(0, 4, 5, 0, 0, 1, 4, 16'hBEEF, 0);
    idle(4, 5);

    $display("[TB] two writers to r3");
    apply_stimulus(0, 3, 4, 1, 3, 0, 0, 0, 0);
    apply_stimulus(0, 3, 4, 1, 3, 0, 0, 0, 0);
    idle(3, 4);
    apply_stimulus(0, 3, 4, 0, 0, 1, 3, 16'h0011, 0);
    apply_stimulus(0, 3, 4, 0, 0, 1, 3, 16'h0042, 0);
    idle(3, 4);

    $display("[TB] saturation on r7");
    repeat (3) apply_stimulus(0, 7, 3, 1, 7, 0, 0, 0, 0);
    apply_stimulus(0, 7, 3, 1, 7, 0, 0, 0, 0);
    apply_stimulus(0, 7, 3, 1, 7, 1, 7, 16'h7777, 0);
    apply_stimulus(0, 7, 3, 1, 7, 0, 0, 0, 0);

    $display("[TB] underflow and flush");
    apply_stimulus(0, 9, 2, 0, 0, 1, 9, 16'h0909, 0);
    idle(9, 2);
    apply_stimulus(0, 9, 2, 0, 0, 1, 2, 16'h2222, 0);
    apply_stimulus(0, 9, 2, 1, 2, 0, 0, 0, 0);
    apply_stimulus(0, 9, 2, 1, 2, 0, 0, 0, 0);
    idle(2, 9);
    apply_stimulus(0, 2, 9, 1, 2, 1, 7, 16'hABCD, 1);
    idle(2, 7);

    $display("[TB] zero register");
    apply_stimulus(0, 0, 2, 0, 0, 1, 0, 16'hFFFF, 0);
    apply_stimulus(0, 0, 2, 1, 0, 0, 0, 0, 0);
    idle(0, 2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      ra_a   = reg_addr_t'(narrow ? $urandom_range(0, 4) : $urandom_range(0, NUM_REGS - 1));
      ra_b   = reg_addr_t'(narrow ? $urandom_range(0, 4) : $urandom_range(0, NUM_REGS - 1));
      a_addr = reg_addr_t'(narrow ? $urandom_range(0, 4) : $urandom_range(0, NUM_REGS - 1));
      w_addr = reg_addr_t'(narrow ? $urandom_range(0, 4) : $urandom_range(0, NUM_REGS - 1));
      apply_stimulus((i == 300), int'(ra_a), int'(ra_b),
                     ($urandom_range(0, 1) == 1), int'(a_addr),
                     ($urandom_range(0, 2) == 0), int'(w_addr), int'($urandom_range(0, 16'hFFFF)),
                     ($urandom_range(0, 31) == 0));
    end
    idle(1, 2);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual %0d required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
